// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter sequencing controller.
// Purely declarative: no latency, no flow control.
// State encoding is referenced by the controller FSM only.
package counter_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/load_counter.sv
// Loadable down-counter with enable and a zero flag.
// Latency: load/decrement visible one cycle later; zero is combinational from q.
// No backpressure: load has priority over enable every cycle.
module load_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= q - W'(1);
        end
    end

    assign zero = (q == '0);

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller for a prescaled programmable down-counter.
// Latency: count/tick/busy/done registered (one cycle); cfg_ready decoded from state.
// Backpressure: cfg_ready low while running; cfg_valid is simply ignored then.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_period,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_reload,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  busy,
    output logic                  done
);

    state_t                  state;
    state_t                  state_nxt;

    logic [WIDTH-1:0]        period_q;
    logic [PRESCALE_W-1:0]   prescale_q;
    logic                    reload_q;

    logic                    stop_act;
    logic                    start_act;
    logic                    cfg_hs;
    logic                    counting;
    logic                    step;
    logic                    terminal;
    logic [WIDTH-1:0]        run_period;
    logic [PRESCALE_W-1:0]   run_prescale;

    logic                    cnt_load;
    logic                    cnt_en;
    logic [WIDTH-1:0]        cnt_load_val;
    logic                    cnt_zero;
    logic                    psc_load;
    logic                    psc_en;
    logic [PRESCALE_W-1:0]   psc_load_val;
    logic                    psc_zero;
    logic [PRESCALE_W-1:0]   psc_val_unused;

    logic                    tick_nxt;
    logic                    busy_nxt;
    logic                    done_nxt;

    // Command arbitration: stop beats start beats a config handshake.
    assign cfg_ready    = (state == IDLE) || (state == ARMED) || (state == DONE);
    assign stop_act     = stop && (state != IDLE);
    assign cfg_hs       = cfg_valid && cfg_ready && !stop_act;
    assign start_act    = start && (state != IDLE) && !stop_act;
    assign counting     = ((state == RUN) || (state == PAUSE)) && !pause && !stop_act && !start_act;
    assign step         = counting && psc_zero;
    assign terminal     = step && cnt_zero;
    assign run_period   = cfg_hs ? cfg_period   : period_q;
    assign run_prescale = cfg_hs ? cfg_prescale : prescale_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q   <= '0;
            prescale_q <= '0;
            reload_q   <= 1'b0;
        end else if (cfg_hs) begin
            period_q   <= cfg_period;
            prescale_q <= cfg_prescale;
            reload_q   <= cfg_reload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop_act) begin
            state_nxt = IDLE;
        end else if (start_act) begin
            state_nxt = RUN;
        end else if (cfg_hs) begin
            state_nxt = ARMED;
        end else if ((state == RUN) || (state == PAUSE)) begin
            if (pause) begin
                state_nxt = PAUSE;
            end else if (terminal && !reload_q) begin
                state_nxt = DONE;
            end else begin
                state_nxt = RUN;
            end
        end
    end

    // The prescaler counts down from prescale to 0; reaching 0 is the step.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = period_q;
        psc_load     = 1'b0;
        psc_en       = 1'b0;
        psc_load_val = prescale_q;
        if (stop_act) begin
            cnt_load     = 1'b1;
            cnt_load_val = '0;
            psc_load     = 1'b1;
            psc_load_val = '0;
        end else if (start_act) begin
            cnt_load     = 1'b1;
            cnt_load_val = run_period;
            psc_load     = 1'b1;
            psc_load_val = run_prescale;
        end else if (counting) begin
            psc_load = psc_zero;
            psc_en   = !psc_zero;
            cnt_load = terminal && reload_q;
            cnt_en   = step && !cnt_zero;
        end
    end

    always_comb begin
        tick_nxt = terminal;
        busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            tick <= tick_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    load_counter #(.W(WIDTH)) u_count (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .q        (count),
        .zero     (cnt_zero)
    );

    // Only the prescaler's zero flag matters; its value is never observed.
    load_counter #(.W(PRESCALE_W)) u_psc (
        .clk      (clk),
        .reset    (reset),
        .load     (psc_load),
        .load_val (psc_load_val),
        .en       (psc_en),
        .q        (psc_val_unused),
        .zero     (psc_zero)
    );

endmodule
